// File: rtl/ser_pkg.sv
// Shared definitions for the parallel-to-serial converter: the FSM state type
// and the default word width.
package ser_pkg;

  localparam int SER_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ser_state_e;

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register whose head bit is either the MSB or the LSB.
// Vacated positions fill with zero.
module ser_shift_reg
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             head
);

  logic [WIDTH-1:0] sr_q, sr_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  // NOTE: state flops use non-blocking assignments and reset asynchronously,
  // so the register clears the moment rst_n falls, not at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign head = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial converter: accepts a word in IDLE, streams it one bit per
// downstream handshake, then pulses done for one cycle before reloading.
module byte_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             busy,
  output logic             done
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;
  logic             shift;
  logic             head;

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (din),
    .head  (head)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The counter parks on the last index rather than wrapping.
        if (sout_ready) begin
          shift = 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Every output decodes registered state only; the async reset reaches them
  // without waiting for a clock edge.
  assign load_ready = (state_q == IDLE);
  assign sout_valid = (state_q == SHIFT);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign sout       = sout_valid & head;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: three instances (8-bit MSB-first, 8-bit LSB-first,
// 2-bit MSB-first) compared every cycle against a word/bit-count model.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic       sout_ready = 1'b0;
  logic [7:0] din8 = '0;
  logic [1:0] din2 = '0;

  logic so_m, sv_m, lr_m, bz_m, dn_m;
  logic so_l, sv_l, lr_l, bz_l, dn_l;
  logic so_2, sv_2, lr_2, bz_2, dn_2;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the word in flight, how many bits remain, and a pending done.
  int m_word[3];
  int m_rem[3];
  bit m_dp[3];
  int m_w[3]   = '{8, 8, 2};
  bit m_msb[3] = '{1'b1, 1'b0, 1'b1};

  logic [7:0] obs8 = '0;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .din(din8), .load_valid(load_valid),
    .load_ready(lr_m), .sout(so_m), .sout_valid(sv_m), .sout_ready(sout_ready),
    .busy(bz_m), .done(dn_m)
  );

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .din(din8), .load_valid(load_valid),
    .load_ready(lr_l), .sout(so_l), .sout_valid(sv_l), .sout_ready(sout_ready),
    .busy(bz_l), .done(dn_l)
  );

  byte_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) dut_2 (
    .clk(clk), .rst_n(rst_n), .din(din2), .load_valid(load_valid),
    .load_ready(lr_2), .sout(so_2), .sout_valid(sv_2), .sout_ready(sout_ready),
    .busy(bz_2), .done(dn_2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected {sout, sout_valid, load_ready, busy, done} for instance k.
  function automatic logic [4:0] exp_out(input int k);
    int  pos;
    int  idx;
    logic so;
    logic idle;
    so = 1'b0;
    if (m_rem[k] > 0) begin
      pos = m_w[k] - m_rem[k];
      idx = m_msb[k] ? (m_w[k] - 1 - pos) : pos;
      so  = ((m_word[k] >> idx) & 1) != 0;
    end
    idle = (m_rem[k] == 0) && !m_dp[k];
    return {so, m_rem[k] > 0, idle, !idle, m_dp[k]};
  endfunction

  task automatic model_step(input int k, input bit lv, input int d, input bit sr);
    if (m_dp[k]) begin
      m_dp[k] = 1'b0;
    end else if (m_rem[k] > 0) begin
      if (sr) begin
        m_rem[k]--;
        if (m_rem[k] == 0) m_dp[k] = 1'b1;
      end
    end else if (lv) begin
      m_word[k] = d;
      m_rem[k]  = m_w[k];
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_word[k] = 0;
      m_rem[k]  = 0;
      m_dp[k]   = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/w8_msb"}, {27'b0, so_m, sv_m, lr_m, bz_m, dn_m}, {27'b0, exp_out(0)});
    check({tag, "/w8_lsb"}, {27'b0, so_l, sv_l, lr_l, bz_l, dn_l}, {27'b0, exp_out(1)});
    check({tag, "/w2_msb"}, {27'b0, so_2, sv_2, lr_2, bz_2, dn_2}, {27'b0, exp_out(2)});
  endtask

  // Compare on the falling edge, then drive the inputs for the next rising edge.
  task automatic cycle(input bit lv, input logic [7:0] d8, input logic [1:0] d2,
                       input bit sr, input string tag);
    @(negedge clk);
    compare_all(tag);
    load_valid = lv;
    din8       = d8;
    din2       = d2;
    sout_ready = sr;
    if (sv_m && sr) obs8 = {obs8[6:0], so_m};
    model_step(0, lv, {24'b0, d8}, sr);
    model_step(1, lv, {24'b0, d8}, sr);
    model_step(2, lv, {30'b0, d2}, sr);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge can act.
  task automatic do_reset(input string tag);
    #2;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    sout_ready = 1'b0;
    model_reset();
    obs8 = '0;
    #1;
    compare_all({tag, "_async"});
    @(posedge clk);
    #1;
    compare_all({tag, "_held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    compare_all("reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 0xA5 with ready held high; 2-bit instance sends 2'b10.
    obs8 = '0;
    cycle(1'b1, 8'hA5, 2'b10, 1'b1, "a5_load");
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1, "a5");
    check("a5_bits", {24'b0, obs8}, 32'hA5);

    // 0x01 exercises the LSB-first instance's single leading one.
    cycle(1'b1, 8'h01, 2'b01, 1'b1, "x01_load");
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1, "x01");

    // 0xF0 with a 3-cycle stall while bit 2 is presented.
    obs8 = '0;
    cycle(1'b1, 8'hF0, 2'b11, 1'b1, "f0_load");
    cycle(1'b0, 8'h00, 2'b00, 1'b1, "f0_bit1");
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 2'b00, 1'b0, "f0_stall");
    for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1, "f0");
    check("f0_bits", {24'b0, obs8}, 32'hF0);

    // load_valid held high: 0xFF then 0x00, second word only after done.
    obs8 = '0;
    cycle(1'b1, 8'hFF, 2'b11, 1'b1, "ff_load");
    for (int i = 0; i < 9; i++) cycle(1'b1, 8'h00, 2'b00, 1'b1, "ff_hold");
    check("ff_bits", {24'b0, obs8}, 32'hFF);
    obs8 = 8'h5A;
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'h00, 2'b00, 1'b1, "x00_hold");
    check("x00_bits", {24'b0, obs8}, 32'h00);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1, "x00_tail");

    // Reset while bit 4 of 0x3C is on sout, then 0x81 from clean state.
    cycle(1'b1, 8'h3C, 2'b10, 1'b1, "x3c_load");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1, "x3c");
    do_reset("x3c_rst");
    cycle(1'b0, 8'h00, 2'b00, 1'b1, "post_rst");
    cycle(1'b1, 8'h81, 2'b01, 1'b1, "x81_load");
    for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1, "x81");
    check("x81_bits", {24'b0, obs8}, 32'h81);

    // Random traffic with random back-pressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 2) == 0, 8'($urandom), 2'($urandom),
            $urandom_range(0, 3) != 0, "rand");
      if ($urandom_range(0, 149) == 0) do_reset("rand_rst");
    end
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 2'b00, 1'b1, "drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 sends din[WIDTH-1] first; 0 sends din[0] first.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 din  input  WIDTH  parallel word from the upstream register.
REQ-006 load_valid  input  1  din is valid this cycle.
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 sout  output  1  current serial bit.
REQ-009 sout_valid  output  1  sout carries a payload bit.
REQ-010 sout_ready  input  1  downstream consumes sout this cycle.
REQ-011 busy  output  1  word in flight.
REQ-012 done  output  1  one-cycle pulse on the cycle the last bit is consumed.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE only.
REQ-014 IDLE: load_ready=1, busy=0, sout_valid=0, sout=0.
REQ-015 IDLE and load_valid=1 -> capture din into shift register, clear bit counter, next state SHIFT.
REQ-016 SHIFT: load_ready=0, busy=1, sout_valid=1; sout = current head bit per MSB_FIRST.
REQ-017 SHIFT with sout_ready=1 -> advance shift register one position, counter+1; sout_ready=0 -> hold sout, shift register and counter unchanged.
REQ-018 SHIFT with sout_ready=1 and counter=WIDTH-1 -> next state DONE.
REQ-019 DONE: lasts exactly one cycle, done=1, sout_valid=0, load_ready=0, busy=1; next state IDLE unconditionally.
REQ-020 done SHALL be 0 in all other states.
REQ-021 Latency: word accepted at edge N; first bit on sout from cycle N+1; with sout_ready held high, done at cycle N+WIDTH+1; load_ready high again at cycle N+WIDTH+2.
REQ-022 load_valid outside IDLE SHALL be ignored; din SHALL NOT affect an in-flight word.
REQ-023 Bit counter width SHALL be $clog2(WIDTH); counter SHALL NOT wrap past WIDTH-1.
REQ-024 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, shift register 0, counter 0, sout=0, sout_valid=0, done=0, busy=0, load_ready=1 (asserted once rst_n is low).
REQ-026 Reset during SHIFT or DONE SHALL discard the in-flight word with no done pulse.
REQ-027 First word SHALL be accepted no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-028 Shared package ser_pkg SHALL hold the state typedef (IDLE/SHIFT/DONE) and the default width constant 8.
REQ-029 Loadable shift register with direction select SHALL be sub-module ser_shift_reg; FSM and counter stay in byte_serializer.

Verification
REQ-030 WIDTH=8, MSB_FIRST=1, din=0xA5, sout_ready=1 -> sout 1,0,1,0,0,1,0,1 on cycles N+1..N+8, done at N+9.
REQ-031 MSB_FIRST=0, din=0x01 -> sout 1,0,0,0,0,0,0,0; sout_valid high exactly 8 cycles.
REQ-032 din=0xF0, sout_ready low for 3 cycles after bit 2 -> bit 2 (value 1) held 4 cycles, sequence otherwise intact, done delayed by 3 cycles.
REQ-033 load_valid held high with din=0xFF then 0x00 -> second word accepted only in IDLE after done; 0xFF fully sent first, din changes mid-shift ignored.
REQ-034 rst_n low during bit 4 of 0x3C -> all outputs reset values immediately, no done, next word 0x81 serialized correctly.
REQ-035 WIDTH=2, din=2'b10 -> sout 1,0, done at N+3, counter never exceeds 1.
